// File: rtl/mseq_checker.sv
// Receive-side checker for the x^4+x+1 m-sequence (period 15).
// Self-synchronises on the serial stream, declares lock after a run of
// correct predictions, then counts checked bits and bit errors for BER
// measurement. Loss of lock is declared when too many mismatches land
// inside one observation window.
module mseq_checker #(
    parameter int CNT_W  = 16,
    parameter int LOCK_N = 8,
    parameter int WIN    = 32,
    parameter int LOSS_N = 6
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       state
);

    localparam int MW = $clog2(LOCK_N + 1);
    localparam int PW = $clog2(WIN + 1);
    localparam int EW = $clog2(LOSS_N + 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state_reg,     state_next;
    logic [3:0]       hist_reg,      hist_next;
    logic [1:0]       fill_cnt_reg,  fill_cnt_next;
    logic [MW-1:0]    match_cnt_reg, match_cnt_next;
    logic [CNT_W-1:0] bit_cnt_reg,   bit_cnt_next;
    logic [CNT_W-1:0] err_cnt_reg,   err_cnt_next;
    logic [PW-1:0]    win_pos_reg,   win_pos_next;
    logic [EW-1:0]    win_err_reg,   win_err_next;
    logic             err_pulse_reg, err_pulse_next;

    // History shifted by one position with the incoming bit entering at [0].
    logic [3:0] hist_shift;
    assign hist_shift[0] = in_bit;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_hist_shift
            assign hist_shift[gi] = hist_reg[gi-1];
        end
    endgenerate

    // b[n] = b[n-4] ^ b[n-1]; four zeros in a row can never occur in the
    // sequence, so a zero following an all-zero history is always an error.
    logic pred;
    logic mis;
    assign pred = hist_reg[3] ^ hist_reg[0];
    assign mis  = (in_bit != pred) | ((hist_reg == 4'b0000) & ~in_bit);

    // Saturating increments and window arithmetic used while locked.
    logic [CNT_W-1:0] bit_cnt_inc;
    logic [CNT_W-1:0] err_cnt_inc;
    logic [PW-1:0]    win_pos_inc;
    logic [EW-1:0]    win_err_inc;
    assign bit_cnt_inc = (&bit_cnt_reg) ? bit_cnt_reg : bit_cnt_reg + CNT_W'(1);
    assign err_cnt_inc = (&err_cnt_reg) ? err_cnt_reg : err_cnt_reg + CNT_W'(1);
    assign win_pos_inc = win_pos_reg + PW'(1);
    assign win_err_inc = win_err_reg + EW'(mis);

    // Next-state and counter updates; nothing moves on cycles without a valid bit.
    always_comb begin
        state_next     = state_reg;
        hist_next      = hist_reg;
        fill_cnt_next  = fill_cnt_reg;
        match_cnt_next = match_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        err_cnt_next   = err_cnt_reg;
        win_pos_next   = win_pos_reg;
        win_err_next   = win_err_reg;
        err_pulse_next = 1'b0;

        if (in_valid) begin
            hist_next = hist_shift;
            case (state_reg)
                ST_FILL: begin
                    if (fill_cnt_reg == 2'd3) begin
                        state_next     = ST_ACQ;
                        match_cnt_next = '0;
                        fill_cnt_next  = '0;
                    end else begin
                        fill_cnt_next = fill_cnt_reg + 2'd1;
                    end
                end
                ST_ACQ: begin
                    if (mis) begin
                        match_cnt_next = '0;
                    end else if (match_cnt_reg == MW'(LOCK_N - 1)) begin
                        state_next     = ST_LOCKED;
                        match_cnt_next = '0;
                        bit_cnt_next   = '0;
                        err_cnt_next   = '0;
                        win_pos_next   = '0;
                        win_err_next   = '0;
                    end else begin
                        match_cnt_next = match_cnt_reg + MW'(1);
                    end
                end
                ST_LOCKED: begin
                    bit_cnt_next = bit_cnt_inc;
                    if (mis) begin
                        err_cnt_next   = err_cnt_inc;
                        err_pulse_next = 1'b1;
                    end
                    // Loss outranks a window wrap on the same bit.
                    if (win_err_inc == EW'(LOSS_N)) begin
                        state_next     = ST_ACQ;
                        match_cnt_next = '0;
                        win_pos_next   = '0;
                        win_err_next   = '0;
                    end else if (win_pos_inc == PW'(WIN)) begin
                        win_pos_next = '0;
                        win_err_next = '0;
                    end else begin
                        win_pos_next = win_pos_inc;
                        win_err_next = win_err_inc;
                    end
                end
                default: begin
                    state_next = ST_FILL;
                end
            endcase
        end
    end

    // State register with asynchronous active-high clear.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            state_reg     <= ST_FILL;
            hist_reg      <= '0;
            fill_cnt_reg  <= '0;
            match_cnt_reg <= '0;
            bit_cnt_reg   <= '0;
            err_cnt_reg   <= '0;
            win_pos_reg   <= '0;
            win_err_reg   <= '0;
            err_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hist_reg      <= hist_next;
            fill_cnt_reg  <= fill_cnt_next;
            match_cnt_reg <= match_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            err_cnt_reg   <= err_cnt_next;
            win_pos_reg   <= win_pos_next;
            win_err_reg   <= win_err_next;
            err_pulse_reg <= err_pulse_next;
        end
    end

    assign locked    = (state_reg == ST_LOCKED);
    assign err_pulse = err_pulse_reg;
    assign bit_cnt   = bit_cnt_reg;
    assign err_cnt   = err_cnt_reg;
    assign state     = state_reg;

endmodule

// File: tb/tb_mseq_checker.sv
// Testbench for mseq_checker: scenario tasks drive the stream, a reference
// model pushes expected outputs per driven cycle into a scoreboard queue,
// and a monitor pops and compares after each clock edge.
module tb_mseq_checker;

    localparam int CNT_W  = 16;
    localparam int LOCK_N = 8;
    localparam int WIN    = 32;
    localparam int LOSS_N = 6;
    localparam int MAXC   = (1 << CNT_W) - 1;
    localparam logic [14:0] SEQ = 15'b000111101011001;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic             in_valid;
    logic             in_bit;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [1:0]       state;

    mseq_checker #(
        .CNT_W (CNT_W),
        .LOCK_N(LOCK_N),
        .WIN   (WIN),
        .LOSS_N(LOSS_N)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .locked   (locked),
        .err_pulse(err_pulse),
        .bit_cnt  (bit_cnt),
        .err_cnt  (err_cnt),
        .state    (state)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int txn    = 0;
    int ph     = 0;

    typedef struct packed {
        logic             lk;
        logic             ep;
        logic [1:0]       st;
        logic [CNT_W-1:0] bc;
        logic [CNT_W-1:0] ec;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // Reference model, written from the behavioural description.
    int   m_state, m_fill, m_match, m_bits, m_errs, m_wpos, m_werr;
    logic m_pulse;
    bit   rx[$];

    task automatic model_reset();
        m_state = 0; m_fill = 0; m_match = 0; m_bits = 0; m_errs = 0;
        m_wpos = 0; m_werr = 0; m_pulse = 1'b0;
        rx.delete();
    endtask

    task automatic model_step(input logic v, input logic b);
        int  idx;
        bit  mis;
        bit  p;
        bit  zr;
        m_pulse = 1'b0;
        if (v) begin
            rx.push_back(b);
            idx = rx.size() - 1;
            mis = 1'b0;
            if (idx >= 4) begin
                p   = rx[idx-4] ^ rx[idx-1];
                zr  = !(rx[idx-4] | rx[idx-3] | rx[idx-2] | rx[idx-1]);
                mis = (b != p) || (zr && !b);
            end
            case (m_state)
                0: begin
                    m_fill++;
                    if (m_fill == 4) begin
                        m_state = 1;
                        m_match = 0;
                    end
                end
                1: begin
                    if (mis) m_match = 0;
                    else begin
                        m_match++;
                        if (m_match == LOCK_N) begin
                            m_state = 2; m_match = 0; m_bits = 0;
                            m_errs = 0; m_wpos = 0; m_werr = 0;
                        end
                    end
                end
                default: begin
                    if (m_bits < MAXC) m_bits++;
                    if (mis) begin
                        if (m_errs < MAXC) m_errs++;
                        m_werr++;
                        m_pulse = 1'b1;
                    end
                    m_wpos++;
                    if (m_werr >= LOSS_N) begin
                        m_state = 1;
                        m_match = 0;
                    end else if (m_wpos == WIN) begin
                        m_wpos = 0;
                        m_werr = 0;
                    end
                end
            endcase
        end
    endtask

    function automatic logic seq_bit(input int p);
        logic [14:0] s;
        s = SEQ;
        return s[14-p];
    endfunction

    // Drive one cycle at the falling edge and queue what the model expects after the next rising edge.
    task automatic drive(input logic v, input logic b);
        exp_t e;
        @(negedge sys_clk);
        in_valid = v;
        in_bit   = b;
        model_step(v, b);
        e.lk = (m_state == 2);
        e.ep = m_pulse;
        e.st = 2'(m_state);
        e.bc = CNT_W'(m_bits);
        e.ec = CNT_W'(m_errs);
        sb_q.push_back(e);
        @(posedge sys_clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        model_reset();
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
    endtask

    // Monitor: compare every scoreboard entry one step after the active edge.
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                txn++;
                $display("txn %0d v=%0b b=%0b locked=%0b pulse=%0b state=%0d bits=%0d errs=%0d",
                         txn, in_valid, in_bit, locked, err_pulse, state, bit_cnt, err_cnt);
                n_cmp++;
                if (locked !== mon_e.lk) begin
                    n_fail++;
                    $display("FAIL sb_locked txn %0d: got %0b want %0b", txn, locked, mon_e.lk);
                end
                n_cmp++;
                if (err_pulse !== mon_e.ep) begin
                    n_fail++;
                    $display("FAIL sb_err_pulse txn %0d: got %0b want %0b", txn, err_pulse, mon_e.ep);
                end
                n_cmp++;
                if (state !== mon_e.st) begin
                    n_fail++;
                    $display("FAIL sb_state txn %0d: got %0d want %0d", txn, state, mon_e.st);
                end
                n_cmp++;
                if (bit_cnt !== mon_e.bc) begin
                    n_fail++;
                    $display("FAIL sb_bit_cnt txn %0d: got %0d want %0d", txn, bit_cnt, mon_e.bc);
                end
                n_cmp++;
                if (err_cnt !== mon_e.ec) begin
                    n_fail++;
                    $display("FAIL sb_err_cnt txn %0d: got %0d want %0d", txn, err_cnt, mon_e.ec);
                end
            end
        end
    end

    task automatic test_reset();
        n_cmp++;
        if (state !== 2'd0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got state=%0d locked=%0b want 0/0", state, locked);
        end
        n_cmp++;
        if (bit_cnt !== '0 || err_cnt !== '0 || err_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_counters: got bits=%0d errs=%0d pulse=%0b want 0", bit_cnt, err_cnt, err_pulse);
        end
    endtask

    task automatic test_clean_lock();
        int lock_at = 0;
        int pulses  = 0;
        ph = 0;
        for (int i = 0; i < 150; i++) begin
            drive(1'b1, seq_bit(ph));
            ph = (ph + 1) % 15;
            if (locked && lock_at == 0) lock_at = i + 1;
            if (err_pulse) pulses++;
        end
        n_cmp++;
        if (lock_at != 12) begin
            n_fail++;
            $display("FAIL clean_lock_point: got bit %0d want 12", lock_at);
        end
        n_cmp++;
        if (bit_cnt !== CNT_W'(138)) begin
            n_fail++;
            $display("FAIL clean_bit_cnt: got %0d want 138", bit_cnt);
        end
        n_cmp++;
        if (err_cnt !== '0 || pulses != 0) begin
            n_fail++;
            $display("FAIL clean_errors: got errs=%0d pulses=%0d want 0/0", err_cnt, pulses);
        end
    endtask

    task automatic test_single_flip();
        logic [19:0] pmask = '0;
        int          lost  = 0;
        logic        b;
        for (int i = 0; i < 20; i++) begin
            b = seq_bit(ph);
            if (i == 5) b = ~b;
            drive(1'b1, b);
            ph = (ph + 1) % 15;
            pmask[i] = err_pulse;
            if (!locked) lost++;
        end
        n_cmp++;
        if (pmask !== 20'h00260) begin
            n_fail++;
            $display("FAIL flip_pulse_offsets: got mask %05h want 00260", pmask);
        end
        n_cmp++;
        if (err_cnt !== CNT_W'(3)) begin
            n_fail++;
            $display("FAIL flip_err_cnt: got %0d want 3", err_cnt);
        end
        n_cmp++;
        if (lost != 0) begin
            n_fail++;
            $display("FAIL flip_lock_kept: got %0d unlocked cycles want 0", lost);
        end
    endtask

    task automatic test_loss_relock();
        int   loss_j = -1, relock_j = -1;
        int   st_loss = -1, ec_loss = -1, bc_rl = -1, ec_rl = -1;
        logic prev_lk;
        logic b;
        do_reset();
        ph = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, seq_bit(ph));
            ph = (ph + 1) % 15;
        end
        prev_lk = locked;
        for (int j = 0; j < 30; j++) begin
            b = seq_bit(ph);
            if (j == 3 || j == 8) b = ~b;
            drive(1'b1, b);
            ph = (ph + 1) % 15;
            if (prev_lk && !locked && loss_j < 0) begin
                loss_j = j; st_loss = int'(state); ec_loss = int'(err_cnt);
            end
            if (loss_j >= 0 && locked && relock_j < 0) begin
                relock_j = j; bc_rl = int'(bit_cnt); ec_rl = int'(err_cnt);
            end
            prev_lk = locked;
        end
        n_cmp++;
        if (loss_j != 12 || st_loss != 1) begin
            n_fail++;
            $display("FAIL loss_point: got bit %0d state %0d want 12/1", loss_j, st_loss);
        end
        n_cmp++;
        if (ec_loss != 6) begin
            n_fail++;
            $display("FAIL loss_err_cnt: got %0d want 6", ec_loss);
        end
        n_cmp++;
        if (relock_j != 20 || bc_rl != 0 || ec_rl != 0) begin
            n_fail++;
            $display("FAIL relock: got bit %0d bits=%0d errs=%0d want 20/0/0", relock_j, bc_rl, ec_rl);
        end
    endtask

    task automatic test_all_zero();
        int lk_seen = 0, bad_st = 0, pulses = 0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'b0);
            if (locked) lk_seen++;
            if (err_pulse) pulses++;
            if (i >= 3 && state !== 2'd1) bad_st++;
        end
        n_cmp++;
        if (lk_seen != 0 || pulses != 0) begin
            n_fail++;
            $display("FAIL zero_no_lock: got locked=%0d pulses=%0d want 0/0", lk_seen, pulses);
        end
        n_cmp++;
        if (bad_st != 0) begin
            n_fail++;
            $display("FAIL zero_stays_acq: got %0d non-ACQ cycles want 0", bad_st);
        end
    endtask

    task automatic test_valid_toggle();
        int   lock_at = 0, vcnt = 0, hold_bad = 0;
        logic p_lk;
        logic [1:0] p_st;
        logic [CNT_W-1:0] p_bc, p_ec;
        logic v;
        do_reset();
        ph = 0;
        for (int i = 0; i < 300; i++) begin
            v = (i % 2 == 0);
            p_lk = locked; p_st = state; p_bc = bit_cnt; p_ec = err_cnt;
            if (v) begin
                drive(1'b1, seq_bit(ph));
                ph = (ph + 1) % 15;
                vcnt++;
                if (locked && lock_at == 0) lock_at = vcnt;
            end else begin
                drive(1'b0, 1'($urandom_range(0, 1)));
                if (locked !== p_lk || state !== p_st || bit_cnt !== p_bc ||
                    err_cnt !== p_ec || err_pulse !== 1'b0) hold_bad++;
            end
        end
        n_cmp++;
        if (lock_at != 12) begin
            n_fail++;
            $display("FAIL toggle_lock_point: got valid bit %0d want 12", lock_at);
        end
        n_cmp++;
        if (bit_cnt !== CNT_W'(138) || err_cnt !== '0) begin
            n_fail++;
            $display("FAIL toggle_counts: got bits=%0d errs=%0d want 138/0", bit_cnt, err_cnt);
        end
        n_cmp++;
        if (hold_bad != 0) begin
            n_fail++;
            $display("FAIL toggle_hold: got %0d idle cycles with changes want 0", hold_bad);
        end
    endtask

    task automatic test_async_reset();
        int lock_at = 0;
        do_reset();
        ph = 0;
        for (int i = 0; i < 22; i++) begin
            drive(1'b1, seq_bit(ph));
            ph = (ph + 1) % 15;
        end
        n_cmp++;
        if (locked !== 1'b1 || bit_cnt !== CNT_W'(10)) begin
            n_fail++;
            $display("FAIL pre_reset_lock: got locked=%0b bits=%0d want 1/10", locked, bit_cnt);
        end
        #1 sys_rst_n = 1'b1;
        #1;
        n_cmp++;
        if (locked !== 1'b0 || state !== 2'd0 || err_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_state: got locked=%0b state=%0d pulse=%0b want 0", locked, state, err_pulse);
        end
        n_cmp++;
        if (bit_cnt !== '0 || err_cnt !== '0) begin
            n_fail++;
            $display("FAIL async_reset_counters: got bits=%0d errs=%0d want 0", bit_cnt, err_cnt);
        end
        model_reset();
        @(negedge sys_clk);
        in_valid = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        ph = 0;
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, seq_bit(ph));
            ph = (ph + 1) % 15;
            if (locked && lock_at == 0) lock_at = i + 1;
        end
        n_cmp++;
        if (lock_at != 12) begin
            n_fail++;
            $display("FAIL post_reset_lock: got bit %0d want 12", lock_at);
        end
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        sys_rst_n = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        model_reset();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #2;
        test_reset();
        test_clean_lock();
        test_single_flip();
        test_loss_relock();
        test_all_zero();
        test_valid_toggle();
        test_async_reset();
        repeat (2) @(posedge sys_clk);
        #3;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mseq_checker.md
Name: mseq_checker

Overview:
Receive-side checker for the 4-stage m-sequence (x^4+x+1, period 15) produced by the upstream sequence generator. It consumes the serial bit stream, self-synchronises to the sequence and declares lock. While locked, it counts received bits and bit errors for BER measurement in the communication experiment.

Parameters:
CNT_W, 16, width of bit and error counters
LOCK_N, 8, consecutive correct predictions required to declare lock
WIN, 32, loss-of-lock observation window length in valid bits
LOSS_N, 6, mismatches within one window that force loss of lock

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  reset, asynchronous, active-high
in_valid  in  1  in_bit is valid this cycle
in_bit  in  1  received serial bit
locked  out  1  checker is synchronised
err_pulse  out  1  one-cycle pulse per mismatch while locked
bit_cnt  out  CNT_W  valid bits checked since lock
err_cnt  out  CNT_W  mismatches since lock
state  out  2  0=FILL, 1=ACQ, 2=LOCKED

Behaviour:
- Reset: sys_rst_n is asynchronous and active-high; clock is sys_clk. Reset clears all registers and outputs to 0 immediately, without waiting for a clock edge. State goes to FILL. Reset during any operation behaves the same way.
- History register hist[3:0], with hist[0] holding the newest bit. On every in_valid: hist <= {hist[2:0], in_bit}. This shift uses the received bit in every state.
- Prediction: pred = hist[3] ^ hist[0], implementing recurrence b[n] = b[n-4] ^ b[n-1].
- Mismatch definition: mis = (in_bit != pred) | (hist == 0 & in_bit == 0). A run of 4 zeros is illegal in the sequence and is always counted as a mismatch.
- When in_valid=0: no register changes, err_pulse=0.
- FILL: count valid bits; after the 4th, go to ACQ with match_cnt=0. No predictions are made.
- ACQ:
  - On mis, match_cnt <= 0.
  - Otherwise match_cnt++.
  - On the LOCK_N-th consecutive match, go to LOCKED and clear bit_cnt, err_cnt, win_pos and win_err.
- LOCKED, per valid bit:
  - bit_cnt++.
  - On mis: err_cnt++, win_err++, and err_pulse=1 for exactly one cycle.
  - win_pos++.
  - If win_err reaches LOSS_N, go to ACQ with match_cnt=0. bit_cnt and err_cnt hold their values until the next lock.
  - On the WIN-th bit of a window, reset win_pos and win_err to 0. If loss and window wrap fall on the same bit, loss takes priority.
- Counters saturate at all-ones and do not wrap.
- Latency: all outputs are registered.
  - Effects of a valid bit sampled at edge k are visible after edge k.
  - locked = (state == LOCKED).
  - locked rises on the edge that samples the 12th valid bit after reset of a clean stream (4 fill + LOCK_N).
- Error signature: a single flipped input bit produces exactly 3 mismatches, at n, n+1 and n+4. The verification model must account for this.

Test Plan:
1. Feed clean period-15 stream 000111101011001 repeating, in_valid=1 continuously -> locked rises at the edge of the 12th bit. After 150 valid bits: err_cnt=0, bit_cnt=138, err_pulse never high.
2. After lock, invert one bit -> exactly 3 err_pulse cycles (bit offsets 0, +1, +4); err_cnt=3; locked remains 1.
3. After lock, invert two bits 5 apart within one window -> 6 mismatches; locked falls on the 6th; state=1. Relocks 8 clean bits later with bit_cnt=err_cnt=0 at relock.
4. All-zero input with in_valid=1 for 100 cycles -> state stays in ACQ after FILL; locked=0 throughout.
5. Test 1 stream with in_valid toggling 1,0,1,0 -> identical lock point and counts in valid-bit terms. Outputs hold during in_valid=0 cycles.
6. Assert sys_rst_n mid-lock between clock edges -> locked, err_pulse, bit_cnt, err_cnt and state are 0 before the next sys_clk edge. Locks again after 12 valid bits once reset is released.
